// File: rtl/sweep_pkg.sv
// Shared types and sizes for the sillyfunction sweep self-test.
package sweep_pkg;

    localparam int unsigned NVEC = 8;
    localparam int unsigned IDXW = 3;
    localparam int unsigned ERRW = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/sillyfunction_sweeper_if.sv
// Stimulus/response and result bus between the sweeper and its surroundings.
interface sillyfunction_sweeper_if;
    import sweep_pkg::*;

    logic            start;
    logic            y;
    logic            a;
    logic            b;
    logic            c;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ERRW-1:0] err_count;
    logic [NVEC-1:0] fail_map;
    logic [NVEC-1:0] captured;

    // Sweeper side: drives stimulus and results, receives start and y.
    modport master (
        input  start, y,
        output a, b, c, busy, done, pass, err_count, fail_map, captured
    );

    // Environment side: issues start, returns y, observes results.
    modport slave (
        output start, y,
        input  a, b, c, busy, done, pass, err_count, fail_map, captured
    );

endinterface

// File: rtl/sillyfunction.sv
// Combinational block under test: y is 1 for {a,b,c} = 000, 100, 101.
module sillyfunction (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (~a & ~b & ~c) | (a & ~b);

endmodule

// File: rtl/sillyfunction_selftest.sv
// Closed-loop wrapper: sweeper stimulus feeds sillyfunction, whose y returns.
module sillyfunction_selftest
    import sweep_pkg::*;
#(
    parameter logic [NVEC-1:0] EXPECTED = 8'h31,
    parameter int unsigned     SETTLE   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [NVEC-1:0] fail_map,
    output logic [NVEC-1:0] captured
);

    sillyfunction_sweeper_if bus ();

    sillyfunction_sweeper #(
        .EXPECTED (EXPECTED),
        .SETTLE   (SETTLE)
    ) u_sweeper (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sillyfunction u_func (
        .a (bus.a),
        .b (bus.b),
        .c (bus.c),
        .y (bus.y)
    );

    assign bus.start = start;
    assign busy      = bus.busy;
    assign done      = bus.done;
    assign pass      = bus.pass;
    assign err_count = bus.err_count;
    assign fail_map  = bus.fail_map;
    assign captured  = bus.captured;

endmodule

// File: rtl/sillyfunction_sweeper.sv
// Drives all eight {a,b,c} vectors, samples y for each and scores it
// against the EXPECTED truth table.
module sillyfunction_sweeper
    import sweep_pkg::*;
#(
    parameter logic [NVEC-1:0] EXPECTED = 8'h31,
    parameter int unsigned     SETTLE   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    sillyfunction_sweeper_if.master   bus
);

    localparam int unsigned CNTW = 4;

    sweep_state_t    state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] abc_q, abc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [NVEC-1:0] fail_q, fail_d;
    logic [NVEC-1:0] cap_q, cap_d;
    logic            mismatch_c;

    assign mismatch_c = bus.y ^ EXPECTED[idx_q];

    // Next-state, counters and result updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        cap_d   = cap_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    abc_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                    cap_d   = '0;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(SETTLE - 1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                cap_d[idx_q]  = bus.y;
                fail_d[idx_q] = mismatch_c;
                err_d         = err_q + ERRW'(mismatch_c);
                if (idx_q == IDXW'(NVEC - 1)) begin
                    // Last vector: finish instead of incrementing the index.
                    state_d = DONE;
                    abc_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + IDXW'(1);
                    cnt_d   = '0;
                    abc_d   = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            cap_q   <= cap_d;
        end
    end

    assign bus.a         = abc_q[2];
    assign bus.b         = abc_q[1];
    assign bus.c         = abc_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_map  = fail_q;
    assign bus.captured  = cap_q;

endmodule

// File: tb/tb_sillyfunction_sweeper.sv
// Directed bench for sillyfunction_sweeper at SETTLE=1 and SETTLE=3.
module tb_sillyfunction_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] y_mode;   // 0: closed loop, 1: force 1, 2: force 0
    logic       sf0_y;
    logic       sf1_y;
    int         total  = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    sillyfunction_sweeper_if bus0 ();
    sillyfunction_sweeper_if bus1 ();

    sillyfunction_sweeper #(.EXPECTED(8'h31), .SETTLE(1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    sillyfunction_sweeper #(.EXPECTED(8'h31), .SETTLE(3)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    sillyfunction u_sf0 (.a(bus0.a), .b(bus0.b), .c(bus0.c), .y(sf0_y));
    sillyfunction u_sf1 (.a(bus1.a), .b(bus1.b), .c(bus1.c), .y(sf1_y));

    assign bus0.y = (y_mode == 2'd0) ? sf0_y : (y_mode == 2'd1);
    assign bus1.y = sf1_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_abc"},  32'({bus0.a, bus0.b, bus0.c}), 32'd0);
        chk({tag, "_busy"}, 32'(bus0.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus0.done), 32'd0);
        chk({tag, "_pass"}, 32'(bus0.pass), 32'd0);
        chk({tag, "_err"},  32'(bus0.err_count), 32'd0);
        chk({tag, "_fail"}, 32'(bus0.fail_map), 32'd0);
        chk({tag, "_cap"},  32'(bus0.captured), 32'd0);
    endtask

    // Start pulse on dut0: returns half a cycle after the sampling edge k.
    task automatic pulse_start0();
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    // From half a cycle after edge k, check done rises exactly after edge k+16.
    task automatic wait_done0(input string tag);
        repeat (15) @(negedge clk);
        chk({tag, "_done_early"}, 32'(bus0.done), 32'd0);
        chk({tag, "_busy_k15"},   32'(bus0.busy), 32'd1);
        @(negedge clk);
        chk({tag, "_done"}, 32'(bus0.done), 32'd1);
        chk({tag, "_busy"}, 32'(bus0.busy), 32'd0);
        chk({tag, "_abc"},  32'({bus0.a, bus0.b, bus0.c}), 32'd0);
    endtask

    task automatic chk_results(input string tag, input logic [7:0] cap,
                               input logic [7:0] fail, input logic [3:0] err,
                               input logic pass);
        chk({tag, "_cap"},  32'(bus0.captured), 32'(cap));
        chk({tag, "_fail"}, 32'(bus0.fail_map), 32'(fail));
        chk({tag, "_err"},  32'(bus0.err_count), 32'(err));
        chk({tag, "_pass"}, 32'(bus0.pass), 32'(pass));
    endtask

    initial begin
        reset      = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        y_mode     = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");

        // Closed-loop sweep, SETTLE=1.
        @(negedge clk);
        pulse_start0();
        chk("cl_busy_k", 32'(bus0.busy), 32'd1);
        chk("cl_abc_k",  32'({bus0.a, bus0.b, bus0.c}), 32'd0);
        repeat (2) @(negedge clk);
        chk("cl_abc_k2", 32'({bus0.a, bus0.b, bus0.c}), 32'd1);
        repeat (11) @(negedge clk);
        chk("cl_abc_k13", 32'({bus0.a, bus0.b, bus0.c}), 32'd6);
        repeat (2) @(negedge clk);
        chk("cl_abc_k15", 32'({bus0.a, bus0.b, bus0.c}), 32'd7);
        @(negedge clk);
        chk("cl_done", 32'(bus0.done), 32'd1);
        chk_results("cl", 8'h31, 8'h00, 4'd0, 1'b1);

        // Restart from DONE with y stuck at 0: results cleared on the start edge.
        y_mode = 2'd2;
        pulse_start0();
        chk("y0_clr_cap",  32'(bus0.captured), 32'd0);
        chk("y0_clr_fail", 32'(bus0.fail_map), 32'd0);
        chk("y0_clr_err",  32'(bus0.err_count), 32'd0);
        chk("y0_clr_done", 32'(bus0.done), 32'd0);
        chk("y0_clr_pass", 32'(bus0.pass), 32'd0);
        wait_done0("y0");
        chk_results("y0", 8'h00, 8'h31, 4'd3, 1'b0);

        // y stuck at 1.
        y_mode = 2'd1;
        pulse_start0();
        wait_done0("y1");
        chk_results("y1", 8'hFF, 8'hCE, 4'd5, 1'b0);

        // start re-pulsed during vector 3 is ignored.
        y_mode = 2'd0;
        pulse_start0();
        repeat (6) @(negedge clk);
        chk("rs_abc_v3", 32'({bus0.a, bus0.b, bus0.c}), 32'd3);
        pulse_start0();
        repeat (8) @(negedge clk);
        chk("rs_done_early", 32'(bus0.done), 32'd0);
        @(negedge clk);
        chk("rs_done", 32'(bus0.done), 32'd1);
        chk_results("rs", 8'h31, 8'h00, 4'd0, 1'b1);

        // Reset (with start also high) during SAMPLE of vector 5.
        pulse_start0();
        repeat (11) @(negedge clk);
        chk("mr_abc_v5",  32'({bus0.a, bus0.b, bus0.c}), 32'd5);
        chk("mr_busy_v5", 32'(bus0.busy), 32'd1);
        reset      = 1'b1;
        bus0.start = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        bus0.start = 1'b0;
        chk_reset_vals("mr");
        @(negedge clk);
        chk("mr_idle_busy", 32'(bus0.busy), 32'd0);
        pulse_start0();
        wait_done0("mr");
        chk_results("mr", 8'h31, 8'h00, 4'd0, 1'b1);

        // SETTLE=3 closed loop: vectors step every 4 cycles, done after 32.
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        chk("s3_busy", 32'(bus1.busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s3_abc_%0d_first", i), 32'({bus1.a, bus1.b, bus1.c}), 32'(i));
            repeat (3) @(negedge clk);
            chk($sformatf("s3_abc_%0d_last", i), 32'({bus1.a, bus1.b, bus1.c}), 32'(i));
            if (i < 7) @(negedge clk);
        end
        chk("s3_done_early", 32'(bus1.done), 32'd0);
        @(negedge clk);
        chk("s3_done", 32'(bus1.done), 32'd1);
        chk("s3_busy_off", 32'(bus1.busy), 32'd0);
        chk("s3_pass", 32'(bus1.pass), 32'd1);
        chk("s3_cap",  32'(bus1.captured), 32'h31);
        chk("s3_err",  32'(bus1.err_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sillyfunction_sweeper.md
# sillyfunction_sweeper

Sequential self-test stage wrapped around the 3-input `sillyfunction` combinational block.
- Upstream role: on `start`, drives `{a,b,c}` through all eight combinations 000..111.
- Downstream role: samples the returned `y` for each vector and compares it against a parameterised expected truth table.
- Reports a captured table, a per-vector fail map, an error count and pass/done status.
- Use: board-level or bench-level check of the combinational stage without a host.

## Interface
Parameters:
- `EXPECTED`, default `8'h31`: expected truth table. Bit i is the expected `y` for `{a,b,c}` = i (1 at 000, 100, 101).
- `SETTLE`, default `1`: cycles each vector is driven before its sample cycle. Legal range 1..15.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin sweep. Sampled in IDLE and DONE only.
- `y` input 1: result from the combinational stage.
- `a`, `b`, `c` outputs, 1 each: registered stimulus, `{a,b,c}` = current vector index.
- `busy` output 1: high in DRIVE and SAMPLE.
- `done` output 1: level, high in DONE.
- `pass` output 1: `done && err_count == 0`.
- `err_count` output 4: number of mismatching vectors, 0..8.
- `fail_map` output 8: bit i = `captured[i] ^ EXPECTED[i]`, written when vector i is sampled.
- `captured` output 8: bit i = `y` sampled for vector i.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- Reset values (all outputs and state):
  - state = IDLE, vector index = 0, settle count = 0.
  - `a`, `b`, `c` = 0; `busy`, `done`, `pass` = 0.
  - `err_count` = 0, `fail_map` = 0, `captured` = 0.
- IDLE --start--> DRIVE:
  - index := 0; clear `captured`, `fail_map`, `err_count`; settle count := 0.
- DRIVE:
  - `{a,b,c}` = index; settle count increments each cycle.
  - After SETTLE cycles, go to SAMPLE.
- SAMPLE (exactly one cycle, `{a,b,c}` unchanged):
  - At the closing edge, `captured[index]` := `y`; `fail_map[index]` := `y ^ EXPECTED[index]`.
  - On mismatch, `err_count` += 1.
  - If index = 7, go to DONE. Otherwise index += 1, settle count := 0, go to DRIVE.
- DONE:
  - `done` = 1; results hold; `{a,b,c}` = 000.
  - `start` re-enters DRIVE with the same clearing as IDLE.
- `start` in DRIVE/SAMPLE is ignored; a sweep cannot be restarted mid-run.
- Index wrap: never increments past 7. The DONE transition replaces the increment.
- `err_count` saturates naturally at 8; overflow is impossible at width 4.
- `reset` mid-sweep (any state) returns every register to its reset value at that edge. No partial results are retained.
- `reset` and `start` high together: `reset` wins; state = IDLE.

## Timing
- `start` high at edge k (in IDLE) → `busy` = 1 and `{a,b,c}` = 000 after edge k.
- Each vector occupies SETTLE+1 cycles. Its sample is taken at the edge ending its SAMPLE cycle.
- `done` rises after edge k + 8·(SETTLE+1). With default SETTLE=1, that is edge k+16.
- `busy` and `done` are never high together.
- `pass` and `done` rise on the same edge.
- Combinational path from `a`, `b`, `c` to `y` has one full DRIVE cycle minimum to settle. The upstream registers are output registers.

## Structure
- Package `sweep_pkg`:
  - `typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} sweep_state_t`
  - `localparam NVEC = 8`, `IDXW = 3`, `ERRW = 4`
- RTL in this block: one state register, index counter, settle counter, and result registers.
- One natural sub-module: `sillyfunction_selftest`, a top wrapper that instantiates `sillyfunction_sweeper` and `sillyfunction`, closing `a`/`b`/`c` → `y`. Benches use it for closed-loop tests.

## Test plan
- Closed loop through `sillyfunction_selftest`, SETTLE=1: pulse `start` → `done` after 16 cycles; `captured` = 8'h31, `fail_map` = 0, `err_count` = 0, `pass` = 1.
- Open loop, bench drives `y` = 1 constantly: sweep completes → `captured` = 8'hFF, `fail_map` = 8'hCE, `err_count` = 5, `pass` = 0.
- `start` re-pulsed during vector 3 → ignored; `done` still rises exactly 16 cycles after the first `start`; results unchanged vs. an undisturbed run.
- `reset` asserted during SAMPLE of vector 5 → next cycle all outputs at reset values. A new `start` then yields the full correct result.
- SETTLE=3, closed loop: `{a,b,c}` steps every 4 cycles (000, 001, …, 111); `done` after 32 cycles; `pass` = 1.
- In DONE, pulse `start` with `y` forced 0 → results cleared on the `start` edge; final `captured` = 8'h00, `err_count` = 3, `fail_map` = 8'h31.
